// File: rtl/pmc_readout_ctrl_if.sv
// Host-side bus of the pixel-matrix readout controller.
// Optional interrupt signals are present only with PMC_READOUT_CTRL_IRQ_EN defined.
interface pmc_readout_ctrl_if;
  localparam int unsigned DIV_W = 8;
  localparam int unsigned CNT_W = 16;

  logic             start;
  logic             abort;
  logic [DIV_W-1:0] clk_div;
  logic             cnt_clr;
  logic             sh;
  logic             pclk;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] frame_cnt;
`ifdef PMC_READOUT_CTRL_IRQ_EN
  logic             irq_clr;
  logic             irq;
`endif

  // Host side: issues requests, observes status
  modport master (
    output start, abort, clk_div, cnt_clr,
`ifdef PMC_READOUT_CTRL_IRQ_EN
    output irq_clr,
    input  irq,
`endif
    input  sh, pclk, busy, done, frame_cnt
  );

  // Controller side
  modport slave (
    input  start, abort, clk_div, cnt_clr,
`ifdef PMC_READOUT_CTRL_IRQ_EN
    input  irq_clr,
    output irq,
`endif
    output sh, pclk, busy, done, frame_cnt
  );
endinterface

// File: rtl/pmc_readout_ctrl.sv
// Pixel-matrix readout controller: shifts one 16-bit frame per start request,
// emitting sh (frame window) and pclk (bit strobe) with div-programmable spacing.
// Optional feature macro: PMC_READOUT_CTRL_IRQ_EN adds irq_clr/irq.
// Outputs are registered from next-state values so they change with the state.
module pmc_readout_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  pmc_readout_ctrl_if.slave  bus
);
  localparam int unsigned DIV_W = 8;
  localparam int unsigned BIT_W = 4;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    GAP   = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] tmr_q, tmr_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic             sh_q, sh_d;
  logic             pclk_q, pclk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             complete;
`ifdef PMC_READOUT_CTRL_IRQ_EN
  logic             irq_q, irq_d;
`endif

  // Next-state, timer, counters and next output values
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    tmr_d    = tmr_q;
    bit_d    = bit_q;
    fcnt_d   = fcnt_q;
    complete = 1'b0;

    if (state_q != IDLE && bus.abort) begin
      state_d = IDLE;
      bit_d   = '0;
      tmr_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            div_d   = bus.clk_div;
            tmr_d   = bus.clk_div;
            state_d = SETUP;
          end
        end
        SETUP, GAP: begin
          if (tmr_q == '0) state_d = PULSE;
          else             tmr_d   = tmr_q - DIV_W'(1);
        end
        PULSE: begin
          bit_d   = bit_q + BIT_W'(1);
          tmr_d   = div_q;
          state_d = (bit_q == '1) ? HOLD : GAP;
        end
        HOLD: begin
          if (tmr_q == '0) begin
            state_d  = IDLE;
            bit_d    = '0;
            complete = 1'b1;
          end else begin
            tmr_d = tmr_q - DIV_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          bit_d   = '0;
          tmr_d   = '0;
        end
      endcase
    end

    // A completion coinciding with a clear counts as the first frame after it
    if (bus.cnt_clr)   fcnt_d = complete ? CNT_W'(1) : '0;
    else if (complete) fcnt_d = fcnt_q + CNT_W'(1);

    sh_d   = (state_d != IDLE);
    busy_d = (state_d != IDLE);
    pclk_d = (state_d == PULSE);
    done_d = complete;
  end

`ifdef PMC_READOUT_CTRL_IRQ_EN
  // Sticky interrupt: a new completion wins over a simultaneous clear
  always_comb begin
    irq_d = irq_q;
    if (complete)         irq_d = 1'b1;
    else if (bus.irq_clr) irq_d = 1'b0;
  end
`endif

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      tmr_q   <= '0;
      bit_q   <= '0;
      fcnt_q  <= '0;
      sh_q    <= 1'b0;
      pclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PMC_READOUT_CTRL_IRQ_EN
      irq_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      fcnt_q  <= fcnt_d;
      sh_q    <= sh_d;
      pclk_q  <= pclk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PMC_READOUT_CTRL_IRQ_EN
      irq_q   <= irq_d;
`endif
    end
  end

  assign bus.sh        = sh_q;
  assign bus.pclk      = pclk_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.frame_cnt = fcnt_q;
`ifdef PMC_READOUT_CTRL_IRQ_EN
  assign bus.irq       = irq_q;
`endif

endmodule

// File: tb/tb_pmc_readout_ctrl.sv
// Directed bench for pmc_readout_ctrl. Cycle c of a frame is the value seen
// after edge c-1, where edge 0 is the edge that samples start.
module tb_pmc_readout_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  pmc_readout_ctrl_if bus ();

  pmc_readout_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Single comparison point
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs nframes frames from the current idle point and checks every cycle of
  // sh/pclk/busy/done against the timing formula. hold keeps start high for
  // back-to-back frames; otherwise start is pulsed while busy (must be ignored).
  task automatic run_frames(input logic [7:0] div, input int nframes, input bit hold,
                            input bit chg_div, input bit clr_last);
    int p, l, total, m, sh_err, pclk_err, busy_err, done_err, pulses;
    bit e_sh, e_pclk, e_done;
    p = int'(div) + 2;
    l = 17 * p;
    total = nframes * l;
    sh_err = 0; pclk_err = 0; busy_err = 0; done_err = 0; pulses = 0;
    bus.clk_div = div;
    bus.start   = 1'b1;
    step();
    for (int c = 1; c <= total; c++) begin
      m      = ((c - 1) % l) + 1;
      e_sh   = (m < l);
      e_pclk = ((m % p) == 0) && (m <= 16 * p);
      e_done = (m == l);
      if (bus.sh   !== e_sh)   sh_err++;
      if (bus.busy !== e_sh)   busy_err++;
      if (bus.pclk !== e_pclk) pclk_err++;
      if (bus.done !== e_done) done_err++;
      if (bus.pclk === 1'b1)   pulses++;
      bus.start   = hold ? (c < total) : (c == 7 || c == l - 1);
      bus.cnt_clr = clr_last && (c == total - 1);
      if (chg_div && c == 20) bus.clk_div = 8'd0;
      if (c < total) step();
    end
    bus.start   = 1'b0;
    bus.cnt_clr = 1'b0;
    check_eq("sh_pattern_errs",   32'(sh_err),   32'd0);
    check_eq("busy_pattern_errs", 32'(busy_err), 32'd0);
    check_eq("pclk_pattern_errs", 32'(pclk_err), 32'd0);
    check_eq("done_pattern_errs", 32'(done_err), 32'd0);
    check_eq("pclk_count",        32'(pulses),   32'(16 * nframes));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_sh"},   32'(bus.sh),        32'd0);
    check_eq({tag, "_pclk"}, 32'(bus.pclk),      32'd0);
    check_eq({tag, "_busy"}, 32'(bus.busy),      32'd0);
    check_eq({tag, "_done"}, 32'(bus.done),      32'd0);
    check_eq({tag, "_fcnt"}, 32'(bus.frame_cnt), 32'd0);
`ifdef PMC_READOUT_CTRL_IRQ_EN
    check_eq({tag, "_irq"},  32'(bus.irq),       32'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.clk_div = 8'd0;
    bus.cnt_clr = 1'b0;
`ifdef PMC_READOUT_CTRL_IRQ_EN
    bus.irq_clr = 1'b0;
`endif
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // start together with abort in IDLE stays idle; lone abort has no effect
    bus.start = 1'b1; bus.abort = 1'b1;
    step();
    check_eq("start_abort_idle_busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    step();
    check_eq("abort_idle_busy", 32'(bus.busy), 32'd0);
    bus.abort = 1'b0;
    step();

    // div=0 frame: pclk at 2..32, done at 34
    run_frames(8'd0, 1, 1'b0, 1'b0, 1'b0);
    check_eq("fcnt_after_f1", 32'(bus.frame_cnt), 32'd1);
    step();

    // div=3 frame with clk_div changed mid-frame
    run_frames(8'd3, 1, 1'b0, 1'b1, 1'b0);
    check_eq("fcnt_after_f2", 32'(bus.frame_cnt), 32'd2);
    step();

    // abort sampled at edge 10
    bus.clk_div = 8'd0;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c < 10; c++) step();
    check_eq("pre_abort_busy", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check_eq("abort_sh",   32'(bus.sh),   32'd0);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_done", 32'(bus.done), 32'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      step();
    end
    check_eq("abort_quiet", 32'(seen), 32'd0);
    check_eq("abort_fcnt",  32'(bus.frame_cnt), 32'd2);
    run_frames(8'd0, 1, 1'b0, 1'b0, 1'b0);
    check_eq("fcnt_after_abort_frame", 32'(bus.frame_cnt), 32'd3);
    step();

    // start held high: two back-to-back frames, one idle cycle between
    run_frames(8'd0, 2, 1'b1, 1'b0, 1'b0);
    check_eq("fcnt_after_b2b", 32'(bus.frame_cnt), 32'd5);
    step();
    check_eq("b2b_release_busy", 32'(bus.busy), 32'd0);

    // wrap and clear-with-completion
    force dut.fcnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.fcnt_q;
    step();
    check_eq("fcnt_preload", 32'(bus.frame_cnt), 32'hFFFF);
    run_frames(8'd0, 1, 1'b0, 1'b0, 1'b0);
    check_eq("fcnt_wrap", 32'(bus.frame_cnt), 32'd0);
    step();
    run_frames(8'd0, 1, 1'b0, 1'b0, 1'b1);
    check_eq("fcnt_clr_with_done", 32'(bus.frame_cnt), 32'd1);
    bus.cnt_clr = 1'b1;
    step();
    bus.cnt_clr = 1'b0;
    check_eq("fcnt_clr", 32'(bus.frame_cnt), 32'd0);
    step();

    // reset at edge 20 of a frame overrides start/abort/cnt_clr
    run_frames(8'd0, 1, 1'b0, 1'b0, 1'b0);
    check_eq("fcnt_pre_reset", 32'(bus.frame_cnt), 32'd1);
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c < 20; c++) step();
    check_eq("pre_reset_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0; bus.start = 1'b1; bus.abort = 1'b1; bus.cnt_clr = 1'b1;
    step();
    check_all_zero("midreset");
    rst_n = 1'b1; bus.start = 1'b0; bus.abort = 1'b0; bus.cnt_clr = 1'b0;
    step();
    check_eq("post_reset_busy", 32'(bus.busy), 32'd0);

`ifdef PMC_READOUT_CTRL_IRQ_EN
    run_frames(8'd0, 1, 1'b0, 1'b0, 1'b0);
    check_eq("irq_set", 32'(bus.irq), 32'd1);
    bus.irq_clr = 1'b1;
    step();
    bus.irq_clr = 1'b0;
    check_eq("irq_clr", 32'(bus.irq), 32'd0);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
